// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Accumulates a programmable number of 5-bit sums coming from an upstream
// 4-bit adder stage (carry in bit 4) into a TOTAL_W-bit running total.
// A run is requested with start while idle. The number of sums (num_samples)
// is captured at that moment. The block then accepts one sum per valid/ready
// handshake until the requested count is reached. Completion is signalled
// with a single-cycle done pulse.
//
// Ports
//   clk          in   1        single clock, all state changes on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        request a new run (honoured only while idle)
//   num_samples  in   4        number of sums in the run, captured on start
//   s_in         in   5        unsigned sum from the upstream adder
//   s_valid      in   1        s_in carries a valid sum
//   s_ready      out  1        block accepts s_in this cycle
//   total        out  TOTAL_W  running / final accumulated sum
//   count        out  4        number of sums accepted in the current run
//   busy         out  1        a run is in progress (accumulating or done)
//   done         out  1        one-cycle pulse at run completion
// -----------------------------------------------------------------------------
module sum_accumulator #(
  parameter int TOTAL_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         num_samples,
  input  logic [4:0]         s_in,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [TOTAL_W-1:0] total,
  output logic [3:0]         count,
  output logic               busy,
  output logic               done
);

  // Zero-extension width for the 5-bit input sum (TOTAL_W is at least 9).
  localparam int PAD_W = TOTAL_W - 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [3:0]         n_r;
  logic [TOTAL_W-1:0] total_r;
  logic [3:0]         count_r;

  logic               accept_start_s;
  logic               xfer_s;
  logic               last_xfer_s;
  logic               ready_s;
  logic               busy_s;
  logic               done_s;
  logic [TOTAL_W-1:0] s_in_ext_s;

  // The handshake depends on the state alone, so s_ready never follows
  // s_valid combinationally.
  assign accept_start_s = (state_r == ST_IDLE) && start;
  assign xfer_s         = ready_s && s_valid;
  // count_r is the number already accepted; this transfer is the N-th one.
  assign last_xfer_s    = xfer_s && (count_r == (n_r - 4'd1));
  assign s_in_ext_s     = {{PAD_W{1'b0}}, s_in};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an unreachable encoding falls back to idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // An empty run goes straight to completion.
          if (num_samples == 4'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_xfer_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
      ST_ACCUM: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
        done_s  = 1'b0;
      end
      ST_DONE: begin
        ready_s = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Run length capture: N is only loaded on an accepted start, so later
  // changes on num_samples cannot disturb a run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r <= 4'd0;
    end else if (accept_start_s) begin
      n_r <= num_samples;
    end else begin
      n_r <= n_r;
    end
  end

  // Accumulator and transfer counter. Both clear on an accepted start and
  // otherwise hold, so the final result stays visible while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_r <= {TOTAL_W{1'b0}};
      count_r <= 4'd0;
    end else if (accept_start_s) begin
      total_r <= {TOTAL_W{1'b0}};
      count_r <= 4'd0;
    end else if (xfer_s) begin
      // Unsigned, wraps modulo 2^TOTAL_W; 15 x 31 fits in the default width.
      total_r <= total_r + s_in_ext_s;
      count_r <= count_r + 4'd1;
    end else begin
      total_r <= total_r;
      count_r <= count_r;
    end
  end

  assign s_ready = ready_s;
  assign busy    = busy_s;
  assign done    = done_s;
  assign total   = total_r;
  assign count   = count_r;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

  localparam int TOTAL_W = 9;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         num_samples = 4'd0;
  logic [4:0]         s_in = 5'd0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [TOTAL_W-1:0] total;
  logic [3:0]         count;
  logic               busy;
  logic               done;

  sum_accumulator #(.TOTAL_W(TOTAL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready), .total(total),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a run is "waiting for m_need more sums"; a completed run
  // shows done for one cycle; otherwise the block is idle. Checked every cycle.
  // ---------------------------------------------------------------------------
  int m_total = 0, m_count = 0, m_need = 0;
  bit m_run = 1'b0, m_done = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_total = 0; m_count = 0; m_need = 0; m_run = 1'b0; m_done = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_run) begin
        if (s_valid) begin
          m_total = (m_total + int'(s_in)) % (1 << TOTAL_W);
          m_count = m_count + 1;
          m_need  = m_need - 1;
          if (m_need == 0) begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start) begin
        m_total = 0;
        m_count = 0;
        m_need  = int'(num_samples);
        if (m_need == 0) m_done = 1'b1;
        else m_run = 1'b1;
      end
      #1;
      chk("model_total",   total,   m_total);
      chk("model_count",   count,   m_count);
      chk("model_s_ready", s_ready, m_run);
      chk("model_busy",    busy,    m_run | m_done);
      chk("model_done",    done,    m_done);
    end
  end

  // Beat tables for one run: valid flag and data per cycle after start.
  bit         beat_v [64];
  logic [4:0] beat_d [64];
  int         nbeats;

  // Starts a run of n sums, plays the beat table, then checks completion.
  task automatic do_run(input string name, input int n, input int exp_total,
                        input int exp_count, input int exp_busy);
    int busy_cyc;
    bit ready_seen;
    busy_cyc   = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; num_samples = 4'(n); s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    num_samples = 4'($urandom);          // must not affect the run
    for (int i = 0; i < nbeats; i++) begin
      busy_cyc += int'(busy);
      ready_seen |= s_ready;
      s_valid = beat_v[i];
      s_in    = beat_d[i];
      start   = 1'($urandom);            // must be ignored while accumulating
      @(negedge clk);
    end
    busy_cyc += int'(busy);
    ready_seen |= s_ready;
    s_valid = 1'b0;
    start   = 1'b0;
    chk({name, "_done"},      done,     1);
    chk({name, "_total"},     total,    exp_total);
    chk({name, "_count"},     count,    exp_count);
    chk({name, "_busy_cyc"},  busy_cyc, exp_busy);
    if (n == 0) chk({name, "_ready_seen"}, ready_seen, 0);
    @(negedge clk);
    chk({name, "_done_gone"}, done,  0);
    chk({name, "_idle"},      busy,  0);
    chk({name, "_hold"},      total, exp_total);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int sum, got, k;
    bit v;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_total", total, 0);
    chk("rst_count", count, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_ready", s_ready, 0);
    chk("rst_done",  done,  0);
    rst_n = 1'b1;

    // 4 sums 5,10,31,0 -> 46
    nbeats = 4;
    beat_v[0] = 1; beat_d[0] = 5'd5;
    beat_v[1] = 1; beat_d[1] = 5'd10;
    beat_v[2] = 1; beat_d[2] = 5'd31;
    beat_v[3] = 1; beat_d[3] = 5'd0;
    do_run("basic4", 4, 46, 4, 5);

    // 15 x 31 = 465, no wrap, busy for 16 cycles
    nbeats = 15;
    for (int i = 0; i < 15; i++) begin beat_v[i] = 1; beat_d[i] = 5'd31; end
    do_run("max15", 15, 465, 15, 16);

    // Gapped valid: 7,-,-,8,-,9 -> 24
    nbeats = 6;
    beat_v[0] = 1; beat_d[0] = 5'd7;
    beat_v[1] = 0; beat_d[1] = 5'($urandom);
    beat_v[2] = 0; beat_d[2] = 5'($urandom);
    beat_v[3] = 1; beat_d[3] = 5'd8;
    beat_v[4] = 0; beat_d[4] = 5'($urandom);
    beat_v[5] = 1; beat_d[5] = 5'd9;
    do_run("gapped3", 3, 24, 3, 7);

    // Empty run
    nbeats = 0;
    do_run("empty", 0, 0, 0, 1);

    // Reset mid-run after 2 of 4 transfers
    @(negedge clk);
    start = 1'b1; num_samples = 4'd4;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_in = 5'd6;
    @(negedge clk);
    s_in = 5'd9;
    @(negedge clk);
    s_valid = 1'b0;
    chk("midrun_total", total, 15);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_total", total, 0);
    chk("arst_count", count, 0);
    chk("arst_busy",  busy,  0);
    chk("arst_ready", s_ready, 0);
    chk("arst_done",  done,  0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    nbeats = 1; beat_v[0] = 1; beat_d[0] = 5'd3;
    do_run("after_rst", 1, 3, 1, 2);

    // start held high across a run
    @(negedge clk);
    start = 1'b1; num_samples = 4'd2; s_valid = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_in = 5'd4;
    @(negedge clk);
    s_in = 5'd6;
    @(negedge clk);
    chk("held_done",  done,  1);
    chk("held_total", total, 10);
    s_valid = 1'b0; num_samples = 4'd1;
    @(negedge clk);
    chk("held_idle_busy",  busy,  0);
    chk("held_idle_total", total, 10);
    @(negedge clk);
    chk("held_restart_busy",  busy,  1);
    chk("held_restart_total", total, 0);
    chk("held_restart_count", count, 0);
    s_valid = 1'b1; s_in = 5'd17;
    @(negedge clk);
    chk("held_second_done",  done,  1);
    chk("held_second_total", total, 17);
    start = 1'b0; s_valid = 1'b0;
    @(negedge clk);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 15);
      sum = 0; got = 0; k = 0;
      while (got < n) begin
        v = (($urandom % 4) != 0) || (k >= 48);
        beat_v[k] = v;
        beat_d[k] = 5'($urandom_range(0, 31));
        if (v) begin got++; sum += int'(beat_d[k]); end
        k++;
      end
      nbeats = k;
      do_run("rand", n, sum, n, k + 1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter TOTAL_W, default 9, as the width of the accumulated total; 9 holds 15 x 31 = 465.
REQ-002 The block SHALL have port clk, input, 1, as the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, as the asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1, to request a new accumulation run.
REQ-005 The block SHALL have port num_samples, input, 4, as the number of sums to accumulate in the run; it is sampled on an accepted start only.
REQ-006 The block SHALL have port s_in, input, 5, as the unsigned 5-bit sum from the upstream 4-bit adder stage, carry in bit 4.
REQ-007 The block SHALL have port s_valid, input, 1, to indicate that s_in is valid.
REQ-008 The block SHALL have port s_ready, output, 1, to indicate that the block accepts s_in this cycle.
REQ-009 The block SHALL have port total, output, TOTAL_W, as the running or final accumulated sum.
REQ-010 The block SHALL have port count, output, 4, as the number of sums accepted in the current run.
REQ-011 The block SHALL have port busy, output, 1, asserted while a run is in progress.
REQ-012 The block SHALL have port done, output, 1, as a one-cycle pulse at run completion.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-014 In IDLE, start=1 SHALL latch num_samples into internal N, clear total and count, and go to ACCUM (N!=0) or DONE (N==0) on the next edge.
REQ-015 In ACCUM, s_ready SHALL be 1, combinationally derived from state only and never from s_valid.
REQ-016 A transfer SHALL occur when s_valid=1 and s_ready=1; on that edge total <= total + zero-extended s_in and count <= count + 1.
REQ-017 A transfer with count == N-1 SHALL move the FSM to DONE; otherwise the FSM SHALL stay in ACCUM.
REQ-018 ACCUM with s_valid=0 SHALL hold total, count and state unchanged, with no timeout.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in ACCUM and DONE and 0 in IDLE.
REQ-021 s_ready SHALL be 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in ACCUM and DONE; a new run requires start in IDLE.
REQ-023 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum of one IDLE cycle between runs.
REQ-024 total and count SHALL hold their final values in IDLE until the next accepted start.
REQ-025 The addition SHALL be unsigned and modulo 2^TOTAL_W, with no overflow flag; TOTAL_W >= 9 cannot overflow.
REQ-026 Latency from the last transfer to done SHALL be 1 cycle: the transfer edge enters DONE and done is high that cycle.
REQ-027 A run with N==0 SHALL assert done one cycle after start, with total=0 and count=0.
REQ-028 Changes to num_samples during a run SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, total=0, count=0, N=0, done=0, busy=0 and s_ready=0, regardless of clk.
REQ-030 Reset asserted mid-run SHALL abort the run without a done pulse; after rst_n deasserts, the block SHALL stay in IDLE until start.
REQ-031 Reset deassertion SHALL be sampled on clk; the first edge with rst_n=1 may accept start.

Verification
REQ-032 The bench SHALL cover this case: reset, then start with num_samples=4, then s_in=5,10,31,0 with s_valid held high -> done pulses 1 cycle after the 4th transfer, total=46, count=4.
REQ-033 The bench SHALL cover this case: num_samples=15 with every s_in=31 -> total=465, count=15, no wrap; busy is high for 16 cycles.
REQ-034 The bench SHALL cover this case: num_samples=3 with s_valid toggling 1,0,0,1,0,1 and s_in=7,x,x,8,x,9 -> only the valid beats are summed, total=24, done after the 3rd transfer.
REQ-035 The bench SHALL cover this case: num_samples=0 -> done one cycle after start, total=0, s_ready never high.
REQ-036 The bench SHALL cover this case: rst_n pulsed low between clock edges after 2 of 4 transfers -> outputs clear immediately, no done pulse; a following start with num_samples=1 and s_in=3 gives total=3.
REQ-037 The bench SHALL cover this case: start held high continuously -> start is ignored in ACCUM and DONE, a new run begins on the IDLE cycle after done, and total restarts from 0.
